// File: rtl/wasca_avm_copy_master.sv
// Avalon-MM copy engine: reads a word from the source, writes it to the destination,
// repeating for word_count words with ascending, wrapping word addresses.
module wasca_avm_copy_master #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [CNT_W-1:0]      word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      words_done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest,
  input  logic                  avm_readdatavalid
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  cur_src;
  logic [ADDR_W-1:0]  cur_dst;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   words_inc;

  assign words_inc = words_done + CNT_W'(1);

  // Sequencer and all registered outputs; requests are held untouched while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cur_src        <= '0;
      cur_dst        <= '0;
      count          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      words_done     <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_src    <= src_addr;
            cur_dst    <= dst_addr;
            count      <= word_count;
            words_done <= '0;
            aborted    <= 1'b0;
            busy       <= 1'b1;
            if (word_count == '0) begin
              state <= FIN;
            end else begin
              state          <= RD_REQ;
              avm_read       <= 1'b1;
              avm_byteenable <= {BE_W{1'b1}};
              avm_address    <= src_addr;
            end
          end
        end
        RD_REQ: begin
          if (!avm_waitrequest) begin
            avm_read       <= 1'b0;
            avm_byteenable <= '0;
            state          <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (avm_readdatavalid) begin
            avm_writedata  <= avm_readdata;
            avm_write      <= 1'b1;
            avm_byteenable <= {BE_W{1'b1}};
            avm_address    <= cur_dst;
            state          <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (!avm_waitrequest) begin
            avm_write      <= 1'b0;
            avm_byteenable <= '0;
            words_done     <= words_inc;
            cur_src        <= cur_src + ADDR_W'(1);
            cur_dst        <= cur_dst + ADDR_W'(1);
            // Abort only takes effect here, after the in-flight word is written.
            if ((words_inc == count) || abort) begin
              state   <= FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
              aborted <= (words_inc != count);
            end else begin
              state          <= RD_REQ;
              avm_read       <= 1'b1;
              avm_byteenable <= {BE_W{1'b1}};
              avm_address    <= cur_src + ADDR_W'(1);
            end
          end
        end
        FIN: begin
          // A zero-length run enters FIN with done low and spends one extra cycle busy.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
